umemory_responder: RTL and testbench
====================================

# umemory_responder

Main-memory responder on the far end of the microcode RD/WR command lines. It accepts a read or write request from the microinstruction register, inserts a parameterised number of wait states, and performs the access on an internal word array. It returns read data toward the C-bus mux and a one-cycle acknowledge that the control sequencer uses to hold the current microinstruction until the access completes.

## Interface
- DATA_BUS_WIDTH, 32, width of the address, write-data and read-data buses
- ADDR_BUS_WIDTH, 10, word-index width; the array holds 2^ADDR_BUS_WIDTH words
- WAIT_STATES, 2, extra cycles inserted before each access; legal range 0..15

Ports (one clock; reset is asynchronous and active-low):
- umemory_responder_CLOCK_50  in  1  system clock, rising edge
- umemory_responder_RESET_InLow  in  1  asynchronous active-low reset
- umemory_responder_RD_IN  in  1  read request, held by the MIR until acknowledged
- umemory_responder_WR_IN  in  1  write request, held by the MIR until acknowledged
- umemory_responder_ADDR_IN  in  DATA_BUS_WIDTH  byte address, taken from the A bus
- umemory_responder_DATA_IN  in  DATA_BUS_WIDTH  write data, taken from the B bus
- umemory_responder_DATA_OUT  out  DATA_BUS_WIDTH  read data, driven toward the C-bus mux
- umemory_responder_ACK_OUT  out  1  access complete, one-cycle pulse
- umemory_responder_BUSY_OUT  out  1  high whenever the FSM is not IDLE
- umemory_responder_ERR_OUT  out  1  sticky error flag

## Operation
- FSM states: IDLE, WAIT, ACK.
- In IDLE, a rising edge with RD_IN or WR_IN high accepts the request:
  - latches op, address and write data
  - loads wait counter with WAIT_STATES
  - moves to WAIT
- In WAIT:
  - cnt != 0: decrement the counter and stay in WAIT.
  - cnt == 0: complete the access, set ACK_OUT=1, and go to ACK.
- Completing a read loads DATA_OUT with array[word index]. Completing a write stores the latched data into array[word index].
- In ACK: clear ACK_OUT and return to IDLE. Request lines are ignored during WAIT and ACK.
- Word index = latched ADDR[ADDR_BUS_WIDTH+1:2]. Address bits above that range are ignored, so addresses alias modulo the array size.
- Misaligned request (ADDR[1:0] != 0):
  - no array access
  - DATA_OUT unchanged
  - ERR_OUT set
  - ACK still given with normal timing
- RD_IN and WR_IN both high at acceptance is an illegal op. It is handled as no access, ERR_OUT set, normal ACK timing.
- DATA_OUT holds the last successful read value. Writes and errored requests do not modify it.
- ERR_OUT is sticky and is cleared only by reset.
- Array contents are not reset. Simulation init is all zeros.

## Timing
- Reset values: state IDLE, ACK_OUT=0, BUSY_OUT=0, ERR_OUT=0, DATA_OUT=0, counter=0.
- Reset asserted mid-access aborts the access immediately: no array write occurs and no ACK is issued.
- Request accepted at edge E0. The access completes, and ACK_OUT rises, at edge E0+WAIT_STATES+1. ACK_OUT is high for exactly one cycle.
- BUSY_OUT is high from after E0 through the ACK cycle.
- The sequencer advances the MIR on the edge where ACK_OUT=1; the FSM reaches IDLE on that same edge. The next request is sampled on the following edge.
- Back-to-back accesses therefore cost WAIT_STATES+3 cycles each.
- A write at edge Ew is visible to any read accepted after Ew.

## Structure
- Shared package umemory_pkg holds:
  - FSM state encoding (IDLE/WAIT/ACK, 2 bits)
  - op encoding (NONE, READ, WRITE, ILLEGAL)
  - wait-counter width constant (4)
- Sub-module umemory_array: single-port synchronous RAM with a write enable, parameterised by DATA_BUS_WIDTH/ADDR_BUS_WIDTH, registered read. Completing a read latches that registered output into DATA_OUT.

## Test plan
- Default params. WR addr 0x10, data 0xDEADBEEF, held until ACK, then RD addr 0x10.
  - ACK exactly 3 cycles after each acceptance edge
  - DATA_OUT=0xDEADBEEF on the read ACK
  - ERR_OUT=0
- WAIT_STATES=0. RD addr 0x0 after reset.
  - ACK in the cycle after acceptance
  - DATA_OUT=0
  - BUSY_OUT high exactly 2 cycles
- RD addr 0x12 (misaligned).
  - ACK with normal timing
  - ERR_OUT=1 and stays 1 through later good accesses
  - DATA_OUT unchanged
- RD and WR both high, addr 0x20, data 0x1. Then RD addr 0x20.
  - ERR_OUT=1
  - second read returns prior contents (0), not 0x1
- WR 0x1000 (aliases word 0) with 0xA5A5A5A5, then RD 0x0.
  - returns 0xA5A5A5A5
- WR addr 0x30 data 0x5; assert reset during WAIT; release; RD 0x30.
  - no ACK for the aborted write
  - outputs at reset values
  - read returns 0

Source files
------------

// File: rtl/umemory_pkg.sv
// umemory_pkg: shared FSM/op encodings and counter width for the main-memory responder.
package umemory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        ILLEGAL = 2'd3
    } opT;

    localparam int CNT_WIDTH = 4;

    function automatic opT decodeOp(input logic rd, input logic wr);
        return (rd && wr) ? ILLEGAL : rd ? READ : wr ? WRITE : NONE;
    endfunction

endpackage

// File: rtl/umemory_array.sv
// umemory_array: single-port word RAM with write enable and registered read.
module umemory_array #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int ADDR_BUS_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      wrEn,
    input  logic [ADDR_BUS_WIDTH-1:0] addr,
    input  logic [DATA_BUS_WIDTH-1:0] wrData,
    output logic [DATA_BUS_WIDTH-1:0] rdData
);

    logic [DATA_BUS_WIDTH-1:0] mem [2**ADDR_BUS_WIDTH];

    always_ff @(posedge clk) begin
        if (wrEn) mem[addr] <= wrData;
        rdData <= mem[addr];
    end

endmodule

// File: rtl/umemory_responder.sv
// umemory_responder: RD/WR memory responder with programmable wait states,
// one-cycle ACK and sticky error flag for misaligned or illegal requests.
module umemory_responder
    import umemory_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int ADDR_BUS_WIDTH = 10,
    parameter int WAIT_STATES    = 2
) (
    input  logic                      umemory_responder_CLOCK_50,
    input  logic                      umemory_responder_RESET_InLow,
    input  logic                      umemory_responder_RD_IN,
    input  logic                      umemory_responder_WR_IN,
    input  logic [DATA_BUS_WIDTH-1:0] umemory_responder_ADDR_IN,
    input  logic [DATA_BUS_WIDTH-1:0] umemory_responder_DATA_IN,
    output logic [DATA_BUS_WIDTH-1:0] umemory_responder_DATA_OUT,
    output logic                      umemory_responder_ACK_OUT,
    output logic                      umemory_responder_BUSY_OUT,
    output logic                      umemory_responder_ERR_OUT
);

    stateT                     state, stateNext;
    opT                        op;
    logic [ADDR_BUS_WIDTH+1:0] addrQ;
    logic [DATA_BUS_WIDTH-1:0] dataQ, rdData;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      accept, done, bad, unusedAddrBits;

    assign accept = state == IDLE && (umemory_responder_RD_IN || umemory_responder_WR_IN);
    assign done   = state == WAIT && cnt == '0;
    assign bad    = op == ILLEGAL || addrQ[1:0] != 2'b00;
    assign unusedAddrBits = ^umemory_responder_ADDR_IN[DATA_BUS_WIDTH-1:ADDR_BUS_WIDTH+2];

    // RAM is addressed straight from the bus while idle so the registered read
    // is already valid on the completion edge even with zero wait states.
    umemory_array #(
        .DATA_BUS_WIDTH(DATA_BUS_WIDTH),
        .ADDR_BUS_WIDTH(ADDR_BUS_WIDTH)
    ) memArray (
        .clk   (umemory_responder_CLOCK_50),
        .wrEn  (done && op == WRITE && !bad),
        .addr  (state == IDLE ? umemory_responder_ADDR_IN[ADDR_BUS_WIDTH+1:2] : addrQ[ADDR_BUS_WIDTH+1:2]),
        .wrData(dataQ),
        .rdData(rdData)
    );

    always_ff @(posedge umemory_responder_CLOCK_50 or negedge umemory_responder_RESET_InLow) begin
        if (!umemory_responder_RESET_InLow) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        umemory_responder_ACK_OUT  = state == ACK;
        umemory_responder_BUSY_OUT = state != IDLE;
        stateNext = (state == IDLE) ? (accept ? WAIT : IDLE) :
                    (state == WAIT) ? (done ? ACK : WAIT) : IDLE;
    end

    always_ff @(posedge umemory_responder_CLOCK_50 or negedge umemory_responder_RESET_InLow) begin
        if (!umemory_responder_RESET_InLow) begin
            op    <= NONE;
            addrQ <= '0;
            dataQ <= '0;
            cnt   <= '0;
            umemory_responder_DATA_OUT <= '0;
            umemory_responder_ERR_OUT  <= 1'b0;
        end else begin
            if (accept) begin
                op    <= decodeOp(umemory_responder_RD_IN, umemory_responder_WR_IN);
                addrQ <= umemory_responder_ADDR_IN[ADDR_BUS_WIDTH+1:0];
                dataQ <= umemory_responder_DATA_IN;
                cnt   <= CNT_WIDTH'(WAIT_STATES);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done && bad) umemory_responder_ERR_OUT <= 1'b1;
            if (done && !bad && op == READ) umemory_responder_DATA_OUT <= rdData;
        end
    end

endmodule

// File: tb/tb_umemory_responder.sv
// tb_umemory_responder: randomized + directed bench with a timing/memory model.
module tb_umemory_responder;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int WS = 2;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          rd = 1'b0, wr = 1'b0;
    logic [DW-1:0] addr = '0, data = '0, dOut;
    logic          ack, busy, err;
    logic          rdZ = 1'b0, wrZ = 1'b0;
    logic [DW-1:0] addrZ = '0, dataZ = '0, dOutZ;
    logic          ackZ, busyZ, errZ;

    int checks = 0;
    int passes = 0;

    initial forever #5 clk = ~clk;

    umemory_responder #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .umemory_responder_CLOCK_50   (clk),
        .umemory_responder_RESET_InLow(rstN),
        .umemory_responder_RD_IN      (rd),
        .umemory_responder_WR_IN      (wr),
        .umemory_responder_ADDR_IN    (addr),
        .umemory_responder_DATA_IN    (data),
        .umemory_responder_DATA_OUT   (dOut),
        .umemory_responder_ACK_OUT    (ack),
        .umemory_responder_BUSY_OUT   (busy),
        .umemory_responder_ERR_OUT    (err)
    );

    umemory_responder #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .WAIT_STATES(0)) dutZ (
        .umemory_responder_CLOCK_50   (clk),
        .umemory_responder_RESET_InLow(rstN),
        .umemory_responder_RD_IN      (rdZ),
        .umemory_responder_WR_IN      (wrZ),
        .umemory_responder_ADDR_IN    (addrZ),
        .umemory_responder_DATA_IN    (dataZ),
        .umemory_responder_DATA_OUT   (dOutZ),
        .umemory_responder_ACK_OUT    (ackZ),
        .umemory_responder_BUSY_OUT   (busyZ),
        .umemory_responder_ERR_OUT    (errZ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: a request sampled at edge acc completes at acc+WS+1; the next one
    // can be sampled from acc+WS+3 on. Memory and flags are plain variables.
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    int            cyc = 0, acc = -100, freeAt = 0;
    logic          mRd = 1'b0, mWr = 1'b0;
    logic [DW-1:0] mAddr = '0, mData = '0, expData = '0;
    logic          expErr = 1'b0;

    initial forever begin
        @(posedge clk or negedge rstN);
        if (!rstN) begin
            acc = -100; freeAt = 0; expData = '0; expErr = 1'b0;
        end else begin
            cyc++;
            if (cyc >= freeAt && (rd || wr)) begin
                acc = cyc; freeAt = cyc + WS + 3;
                mRd = rd; mWr = wr; mAddr = addr; mData = data;
            end else if (cyc == acc + WS + 1) begin
                if ((mRd && mWr) || mAddr[1:0] != 2'b00) expErr = 1'b1;
                else if (mWr) mem[mAddr[AW+1:2]] = mData;
                else expData = mem[mAddr[AW+1:2]];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("ack", 32'(ack), 32'(cyc == acc + WS + 1));
        check("busy", 32'(busy), 32'(cyc >= acc && cyc <= acc + WS + 1));
        check("dataOut", dOut, expData);
        check("err", 32'(err), 32'(expErr));
    end

    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
        rd = r; wr = w; addr = a; data = d; lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin lat = i; break; end
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat, busyCnt, ackAt;
        logic [31:0] dAtAck;
        repeat (2) @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        // zero-wait-state instance: read of word 0 right after reset
        rdZ = 1'b1; addrZ = '0; busyCnt = 0; ackAt = -1; dAtAck = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busyZ) busyCnt++;
            if (ackZ) begin ackAt = i; dAtAck = dOutZ; rdZ = 1'b0; end
        end
        check("ws0 ackAt", ackAt, 1);
        check("ws0 busyCycles", busyCnt, 2);
        check("ws0 data", dAtAck, 32'h0);
        check("ws0 err", 32'(errZ), 32'h0);
        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat);
        check("wr10 lat", lat, 3);
        req(1'b1, 1'b0, 32'h10, 32'h0, lat);
        check("rd10 lat", lat, 3);
        check("rd10 data", dOut, 32'hDEADBEEF);
        check("rd10 err", 32'(err), 32'h0);
        // reset during the wait phase of a write
        rd = 1'b0; wr = 1'b1; addr = 32'h30; data = 32'h5;
        repeat (2) @(negedge clk);
        #2 rstN = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("rst ack", 32'(ack), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst data", dOut, 32'h0);
        #2 rstN = 1'b1;
        @(negedge clk);
        req(1'b1, 1'b0, 32'h30, 32'h0, lat);
        check("rd30 lat", lat, 3);
        check("rd30 data", dOut, 32'h0);
        req(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, lat);
        req(1'b1, 1'b0, 32'h0, 32'h0, lat);
        check("alias data", dOut, 32'hA5A5A5A5);
        req(1'b1, 1'b0, 32'h12, 32'h0, lat);
        check("misalign lat", lat, 3);
        check("misalign err", 32'(err), 32'h1);
        check("misalign data", dOut, 32'hA5A5A5A5);
        req(1'b1, 1'b1, 32'h20, 32'h1, lat);
        check("illegal lat", lat, 3);
        check("illegal data", dOut, 32'hA5A5A5A5);
        req(1'b1, 1'b0, 32'h20, 32'h0, lat);
        check("rd20 data", dOut, 32'h0);
        check("rd20 err", 32'(err), 32'h1);
        for (int n = 0; n < 150; n++) begin
            int k, w, mis;
            k = $urandom_range(0, 15);
            w = $urandom_range(0, 15);
            mis = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            req(k < 7 || k == 15, k >= 7,
                32'($urandom_range(0, 3)) * 32'h1000 + 32'(w) * 4 + 32'(mis), $urandom, lat);
            check("rand lat", lat, WS + 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d checks failed so far", checks - passes);
        $fatal(1);
    end

endmodule
